// File: rtl/cr_xp10_decomp_hufd_tbl_bank_ctrl.sv
// rtl/cr_xp10_decomp_hufd_tbl_bank_ctrl.sv - decode-table bank controller between htf and sdd
//
// Tracks NUM_BANKS decode-table banks through FREE -> FILL -> READY -> ACTIVE -> FREE.
// htf fills one bank while sdd decodes another, and completed banks reach sdd in the
// order they were completed.
//
// Optional feature macro: CR_XP10_DECOMP_TBL_BANK_STATS_EN (adds alloc_stall_stb, bank_hwm).
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   htf_alloc_req/gnt/bank      htf asks for a bank; the grant is combinational
//   htf_complete_valid/info     the filling bank is written; its block info is captured
//   htf_abort                   discard the filling bank
//   sdd_blk_valid/bank/info     head of the ready queue offered to sdd
//   sdd_blk_ready               sdd takes the offered bank
//   sdd_blk_done                sdd releases its active bank
//   sdd_active                  a bank is active in sdd
//   free_cnt                    registered count of FREE banks
//   proto_err_stb               registered one-cycle pulse, the cycle after an illegal handshake
//   alloc_stall_stb, bank_hwm   (stats build only) stalled request strobe, busy-bank high-water mark
module cr_xp10_decomp_hufd_tbl_bank_ctrl #(
    parameter int NUM_BANKS = 2,
    parameter int BANK_W    = $clog2(NUM_BANKS),
    parameter int INFO_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              htf_alloc_req,
    output logic              htf_alloc_gnt,
    output logic [BANK_W-1:0] htf_alloc_bank,
    input  logic              htf_complete_valid,
    input  logic [INFO_W-1:0] htf_complete_info,
    input  logic              htf_abort,
    output logic              sdd_blk_valid,
    output logic [BANK_W-1:0] sdd_blk_bank,
    output logic [INFO_W-1:0] sdd_blk_info,
    input  logic              sdd_blk_ready,
    input  logic              sdd_blk_done,
    output logic              sdd_active,
`ifdef CR_XP10_DECOMP_TBL_BANK_STATS_EN
    output logic              alloc_stall_stb,
    output logic [BANK_W:0]   bank_hwm,
`endif
    output logic [BANK_W:0]   free_cnt,
    output logic              proto_err_stb
);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_READY  = 2'd2,
        ST_ACTIVE = 2'd3
    } bank_st_e;

    bank_st_e          st_q   [NUM_BANKS];
    bank_st_e          st_d   [NUM_BANKS];
    logic [INFO_W-1:0] info_q [NUM_BANKS];
    logic [INFO_W-1:0] info_d [NUM_BANKS];
    logic [BANK_W-1:0] fifo_q [NUM_BANKS];
    logic [BANK_W-1:0] fifo_d [NUM_BANKS];
    logic [BANK_W-1:0] head_q, head_d;
    logic [BANK_W-1:0] tail_q, tail_d;
    logic [BANK_W:0]   cnt_q, cnt_d;
    logic [BANK_W:0]   free_cnt_q, free_cnt_d;
    logic              err_q, err_d;

    logic              fill_any, act_any;
    logic [BANK_W-1:0] fill_idx, act_idx, free_idx;
    logic [BANK_W-1:0] head_bank;
    logic              accept;

    // Queue pointers wrap at NUM_BANKS, which need not be a power of two.
    function automatic logic [BANK_W-1:0] ptr_inc(input logic [BANK_W-1:0] p);
        return (p == BANK_W'(NUM_BANKS - 1)) ? '0 : p + 1'b1;
    endfunction

    // Locate the filling bank, the active bank and the lowest-index free bank.
    always_comb begin
        fill_any = 1'b0;
        act_any  = 1'b0;
        fill_idx = '0;
        act_idx  = '0;
        free_idx = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (st_q[i] == ST_FREE) begin
                free_idx = BANK_W'(i);
            end
            if (st_q[i] == ST_FILL) begin
                fill_any = 1'b1;
                fill_idx = BANK_W'(i);
            end
            if (st_q[i] == ST_ACTIVE) begin
                act_any = 1'b1;
                act_idx = BANK_W'(i);
            end
        end
    end

    assign head_bank      = fifo_q[head_q];
    assign htf_alloc_gnt  = htf_alloc_req & ~fill_any & (free_cnt_q != '0);
    assign htf_alloc_bank = htf_alloc_gnt ? free_idx : '0;
    assign sdd_blk_valid  = (cnt_q != '0) & ~act_any;
    assign sdd_blk_bank   = sdd_blk_valid ? head_bank : '0;
    assign sdd_blk_info   = sdd_blk_valid ? info_q[head_bank] : '0;
    assign sdd_active     = act_any;
    assign free_cnt       = free_cnt_q;
    assign proto_err_stb  = err_q;
    assign accept         = sdd_blk_valid & sdd_blk_ready;

    always_comb begin
        st_d   = st_q;
        info_d = info_q;
        fifo_d = fifo_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        err_d  = 1'b0;

        if (sdd_blk_done) begin
            if (act_any) begin
                st_d[act_idx] = ST_FREE;
            end else begin
                err_d = 1'b1;
            end
        end

        // Offer implies no active bank, so this never collides with a real done.
        if (accept) begin
            st_d[head_bank] = ST_ACTIVE;
            head_d          = ptr_inc(head_q);
            cnt_d           = cnt_d - 1'b1;
        end

        // Abort dominates complete; asserting both is itself a protocol error.
        if (htf_abort) begin
            if (fill_any) begin
                st_d[fill_idx] = ST_FREE;
            end else begin
                err_d = 1'b1;
            end
            if (htf_complete_valid) begin
                err_d = 1'b1;
            end
        end else if (htf_complete_valid) begin
            if (fill_any) begin
                st_d[fill_idx]   = ST_READY;
                info_d[fill_idx] = htf_complete_info;
                fifo_d[tail_q]   = fill_idx;
                tail_d           = ptr_inc(tail_q);
                cnt_d            = cnt_d + 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        // A grant only happens with no FILL bank, so free_idx is untouched above.
        if (htf_alloc_gnt) begin
            st_d[free_idx] = ST_FILL;
        end

        free_cnt_d = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (st_d[i] == ST_FREE) begin
                free_cnt_d = free_cnt_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                st_q[i]   <= ST_FREE;
                info_q[i] <= '0;
                fifo_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            free_cnt_q <= (BANK_W + 1)'(NUM_BANKS);
            err_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                st_q[i]   <= st_d[i];
                info_q[i] <= info_d[i];
                fifo_q[i] <= fifo_d[i];
            end
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            free_cnt_q <= free_cnt_d;
            err_q      <= err_d;
        end
    end

`ifdef CR_XP10_DECOMP_TBL_BANK_STATS_EN
    logic [BANK_W:0] bank_hwm_q, bank_hwm_d;
    logic [BANK_W:0] busy_d;

    assign alloc_stall_stb = htf_alloc_req & ~htf_alloc_gnt;
    assign bank_hwm        = bank_hwm_q;

    // Busy count can never exceed NUM_BANKS, so the maximum saturates naturally.
    always_comb begin
        busy_d     = (BANK_W + 1)'(NUM_BANKS) - free_cnt_d;
        bank_hwm_d = (busy_d > bank_hwm_q) ? busy_d : bank_hwm_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_hwm_q <= '0;
        end else begin
            bank_hwm_q <= bank_hwm_d;
        end
    end
`endif

endmodule
